vape_region_cfg_ctrl: RTL and testbench

Memory-mapped configuration and sequencing controller for the VAPE/ASAP hardware monitor. Holds the ER (executable region) and OR (output region) bounds that drive the monitor's ER_min/ER_max/OR_min/OR_max inputs. Validates a configuration on commit and locks it while the attested region is armed or running. Tracks the region lifecycle from pc and the monitor's exec flag, and exposes status to software.

---
 rtl/vape_region_cfg_ctrl_if.sv | 33 +++
 rtl/vape_region_cfg_ctrl.sv | 173 +++++++++++++++++
 tb/tb_vape_region_cfg_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vape_region_cfg_ctrl_if.sv
// CPU data-bus view of the VAPE region configuration window.
// master: CPU side (drives strobes/address/data); slave: register block.
interface vape_region_cfg_ctrl_if;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
`ifdef VAPE_CFG_READBACK_EN
  logic [15:0] data_rdata;
`endif

  modport master (
    output data_en,
    output data_wr,
    output data_addr,
    output data_wdata
`ifdef VAPE_CFG_READBACK_EN
    ,
    input  data_rdata
`endif
  );

  modport slave (
    input  data_en,
    input  data_wr,
    input  data_addr,
    input  data_wdata
`ifdef VAPE_CFG_READBACK_EN
    ,
    output data_rdata
`endif
  );
endinterface

// File: rtl/vape_region_cfg_ctrl.sv
// VAPE/ASAP region config + lifecycle controller (ER/OR bounds, commit/lock).
// Ports: clk, puc (async high reset), pc, exec_in, bus (cfg window),
// ER/OR bounds out, state, cfg_err, cfg_locked.
// Optional: VAPE_CFG_READBACK_EN adds bus.data_rdata register readback.
module vape_region_cfg_ctrl #(
  parameter logic [15:0] CFG_BASE = 16'h0190,
  parameter logic [15:0] ER_RST   = 16'hFFFE,
  parameter logic [15:0] OR_RST   = 16'hFFFE
) (
  input  logic                          clk,
  input  logic                          puc,
  input  logic [15:0]                   pc,
  input  logic                          exec_in,
  vape_region_cfg_ctrl_if.slave         bus,
  output logic [15:0]                   ER_min,
  output logic [15:0]                   ER_max,
  output logic [15:0]                   OR_min,
  output logic [15:0]                   OR_max,
  output logic [2:0]                    state,
  output logic                          cfg_err,
  output logic                          cfg_locked
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] er_min_q, er_min_d;
  logic [15:0] er_max_q, er_max_d;
  logic [15:0] or_min_q, or_min_d;
  logic [15:0] or_max_q, or_max_d;
  logic        cfg_err_q, cfg_err_d;

  // Word offset into the window; wraps for addresses below CFG_BASE.
  logic [14:0] off;
  logic        in_win;
  logic        wr;
  logic        ctrl_wr;
  logic        commit;
  logic        clear;
  logic        cfg_ok;
  logic        unused_addr0;

  assign off     = bus.data_addr[15:1] - CFG_BASE[15:1];
  assign in_win  = off < 15'd6;
  assign wr      = bus.data_en & bus.data_wr & in_win;
  assign ctrl_wr = wr & (off == 15'd4);
  assign clear   = ctrl_wr & bus.data_wdata[1];
  assign commit  = ctrl_wr & bus.data_wdata[0] & ~bus.data_wdata[1];
  assign unused_addr0 = bus.data_addr[0];

  // Bounds must be ordered, ER word-aligned, and OR disjoint from ER.
  assign cfg_ok = (er_min_q <= er_max_q) &
                  (or_min_q <= or_max_q) &
                  ~er_min_q[0] & ~er_max_q[0] &
                  ((or_max_q < er_min_q) | (or_min_q > er_max_q));

  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    er_min_d  = er_min_q;
    er_max_d  = er_max_q;
    or_min_d  = or_min_q;
    or_max_d  = or_max_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr) begin
          unique case (1'b1)
            (off == 15'd0): er_min_d = bus.data_wdata;
            (off == 15'd1): er_max_d = bus.data_wdata;
            (off == 15'd2): or_min_d = bus.data_wdata;
            (off == 15'd3): or_max_d = bus.data_wdata;
            default: ;
          endcase
        end
        if (commit) begin
          if (cfg_ok) begin
            state_d   = ST_ARMED;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (!exec_in) begin
          state_d = ST_FAULT;
        end else if (clear) begin
          state_d   = ST_IDLE;
          cfg_err_d = 1'b0;
        end else if (pc == er_min_q) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (!exec_in) begin
          state_d = ST_FAULT;
        end else if (pc == er_max_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_FAULT: begin
        if (clear) begin
          state_d   = ST_IDLE;
          cfg_err_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge puc) begin
    if (puc) begin
      state_q   <= ST_IDLE;
      cfg_err_q <= 1'b0;
      er_min_q  <= ER_RST;
      er_max_q  <= ER_RST;
      or_min_q  <= OR_RST;
      or_max_q  <= OR_RST;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      er_min_q  <= er_min_d;
      er_max_q  <= er_max_d;
      or_min_q  <= or_min_d;
      or_max_q  <= or_max_d;
    end
  end

  assign ER_min     = er_min_q;
  assign ER_max     = er_max_q;
  assign OR_min     = or_min_q;
  assign OR_max     = or_max_q;
  assign state      = state_q;
  assign cfg_err    = cfg_err_q;
  assign cfg_locked = (state_q == ST_ARMED) | (state_q == ST_RUNNING);

`ifdef VAPE_CFG_READBACK_EN
  logic [15:0] rdata_q, rdata_d;
  logic        rd;

  assign rd = bus.data_en & ~bus.data_wr & in_win;

  always_comb begin
    rdata_d = 16'h0000;
    if (rd) begin
      unique case (1'b1)
        (off == 15'd0): rdata_d = er_min_q;
        (off == 15'd1): rdata_d = er_max_q;
        (off == 15'd2): rdata_d = or_min_q;
        (off == 15'd3): rdata_d = or_max_q;
        (off == 15'd5): rdata_d = {12'b0, cfg_err_q, state_q};
        default:        rdata_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge puc) begin
    if (puc) rdata_q <= 16'h0000;
    else     rdata_q <= rdata_d;
  end

  assign bus.data_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_vape_region_cfg_ctrl.sv
// Directed self-checking bench for vape_region_cfg_ctrl.
// Drives on negedge, samples on the following negedge.
module tb_vape_region_cfg_ctrl;
  localparam logic [15:0] B = 16'h0190;

  logic        clk = 1'b0;
  logic        puc;
  logic [15:0] pc;
  logic        exec_in;
  logic [15:0] er_min, er_max, or_min, or_max;
  logic [2:0]  state;
  logic        cfg_err, cfg_locked;
  int          n_run  = 0;
  int          n_fail = 0;

  vape_region_cfg_ctrl_if bus ();

  vape_region_cfg_ctrl dut (
    .clk       (clk),
    .puc       (puc),
    .pc        (pc),
    .exec_in   (exec_in),
    .bus       (bus),
    .ER_min    (er_min),
    .ER_max    (er_max),
    .OR_min    (or_min),
    .OR_max    (or_max),
    .state     (state),
    .cfg_err   (cfg_err),
    .cfg_locked(cfg_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.data_en = 1'b1; bus.data_wr = 1'b1;
    bus.data_addr = a; bus.data_wdata = d;
    @(negedge clk);
    bus.data_en = 1'b0; bus.data_wr = 1'b0;
  endtask

  task automatic step(input logic [15:0] p, input logic ex);
    @(negedge clk);
    pc = p; exec_in = ex;
    @(negedge clk);
    exec_in = 1'b1;
  endtask

`ifdef VAPE_CFG_READBACK_EN
  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    bus.data_en = 1'b1; bus.data_wr = 1'b0; bus.data_addr = a;
    @(negedge clk);
    bus.data_en = 1'b0;
  endtask
`endif

  initial begin
    puc = 1'b1; pc = 16'h0000; exec_in = 1'b1;
    bus.data_en = 1'b0; bus.data_wr = 1'b0;
    bus.data_addr = 16'h0000; bus.data_wdata = 16'h0000;
    #12;
    chk("rst_ermin", er_min, 16'hFFFE);
    chk("rst_ermax", er_max, 16'hFFFE);
    chk("rst_ormin", or_min, 16'hFFFE);
    chk("rst_ormax", or_max, 16'hFFFE);
    chk("rst_state", {13'b0, state}, 16'd0);
    chk("rst_err", {15'b0, cfg_err}, 16'd0);
    chk("rst_lock", {15'b0, cfg_locked}, 16'd0);
`ifdef VAPE_CFG_READBACK_EN
    chk("rst_rdata", bus.data_rdata, 16'h0000);
`endif
    @(negedge clk);
    puc = 1'b0;

    // Program bounds; OR_min through the odd byte address.
    wr(B + 16'h0, 16'hE000);
    wr(B + 16'h2, 16'hE0FE);
    wr(B + 16'h5, 16'h0200);
    wr(B + 16'h6, 16'h02FE);
    chk("wr_ermin", er_min, 16'hE000);
    chk("wr_ermax", er_max, 16'hE0FE);
    chk("wr_odd_ormin", or_min, 16'h0200);
    chk("wr_ormax", or_max, 16'h02FE);

    // Outside the window: no effect.
    wr(B + 16'hC, 16'h1111);
    wr(B - 16'h2, 16'h2222);
    chk("oow_ermin", er_min, 16'hE000);
    chk("oow_ormax", or_max, 16'h02FE);
    chk("oow_state", {13'b0, state}, 16'd0);

    // COMMIT+CLEAR in IDLE: commit discarded.
    wr(B + 16'h8, 16'h0003);
    chk("both_idle_state", {13'b0, state}, 16'd0);

    wr(B + 16'h8, 16'h0001);
    chk("commit_state", {13'b0, state}, 16'd1);
    chk("commit_lock", {15'b0, cfg_locked}, 16'd1);
    chk("commit_err", {15'b0, cfg_err}, 16'd0);

`ifdef VAPE_CFG_READBACK_EN
    rd(B + 16'hA);
    chk("rb_status", bus.data_rdata, 16'h0001);
    rd(B + 16'h8);
    chk("rb_ctrl", bus.data_rdata, 16'h0000);
    rd(B + 16'h2);
    chk("rb_ermax", bus.data_rdata, 16'hE0FE);
    @(negedge clk);
    chk("rb_idle", bus.data_rdata, 16'h0000);
`endif

    wr(B + 16'h0, 16'h1234);
    chk("locked_drop", er_min, 16'hE000);

    // Lifecycle.
    step(16'hE002, 1'b1);
    chk("armed_hold", {13'b0, state}, 16'd1);
    step(16'hE000, 1'b1);
    chk("run_state", {13'b0, state}, 16'd2);
    chk("run_lock", {15'b0, cfg_locked}, 16'd1);
    pc = 16'hE010;
    wr(B + 16'h8, 16'h0002);
    chk("run_clear_ign", {13'b0, state}, 16'd2);
    step(16'hE0FE, 1'b1);
    chk("done_state", {13'b0, state}, 16'd3);
    chk("done_lock", {15'b0, cfg_locked}, 16'd0);
    pc = 16'h0000;
    wr(B + 16'h8, 16'h0002);
    chk("done_clear", {13'b0, state}, 16'd0);

    // Invalid commit: OR overlaps ER.
    wr(B + 16'h4, 16'hE010);
    wr(B + 16'h8, 16'h0001);
    chk("ovl_state", {13'b0, state}, 16'd0);
    chk("ovl_err", {15'b0, cfg_err}, 16'd1);
    wr(B + 16'h8, 16'h0002);
    chk("idle_clear_err", {15'b0, cfg_err}, 16'd1);
    wr(B + 16'h4, 16'h0200);
    wr(B + 16'h8, 16'h0001);
    chk("fix_state", {13'b0, state}, 16'd1);
    chk("fix_err", {15'b0, cfg_err}, 16'd0);

    // Fault beats pc==ER_max.
    step(16'hE000, 1'b1);
    chk("f_run", {13'b0, state}, 16'd2);
    step(16'hE0FE, 1'b0);
    chk("fault_state", {13'b0, state}, 16'd4);
    step(16'h0000, 1'b1);
    chk("fault_hold", {13'b0, state}, 16'd4);
    wr(B + 16'h8, 16'h0002);
    chk("fault_clear", {13'b0, state}, 16'd0);

    // Odd ER_min rejected.
    wr(B + 16'h0, 16'hE001);
    wr(B + 16'h8, 16'h0001);
    chk("odd_err", {15'b0, cfg_err}, 16'd1);
    chk("odd_state", {13'b0, state}, 16'd0);

    // Single-instruction region; then fault while ARMED.
    wr(B + 16'h0, 16'hE000);
    wr(B + 16'h2, 16'hE000);
    wr(B + 16'h8, 16'h0001);
    chk("single_arm", {13'b0, state}, 16'd1);
    step(16'hE000, 1'b1);
    chk("single_run", {13'b0, state}, 16'd2);
    step(16'hE000, 1'b1);
    chk("single_done", {13'b0, state}, 16'd3);
    pc = 16'h0000;
    wr(B + 16'h8, 16'h0003);
    chk("both_done", {13'b0, state}, 16'd0);
    wr(B + 16'h8, 16'h0001);
    step(16'h0000, 1'b0);
    chk("armed_fault", {13'b0, state}, 16'd4);
    wr(B + 16'h8, 16'h0002);

    // Async puc mid-RUNNING.
    wr(B + 16'h8, 16'h0001);
    step(16'hE000, 1'b1);
    chk("pre_puc_run", {13'b0, state}, 16'd2);
    #2 puc = 1'b1;
    #1;
    chk("puc_state", {13'b0, state}, 16'd0);
    chk("puc_ermin", er_min, 16'hFFFE);
    chk("puc_lock", {15'b0, cfg_locked}, 16'd0);
    @(negedge clk);
    puc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
